spi_reg_ctrl: RTL and testbench

Command sequencer between `SPI_Slave` and an on-chip register bank. It watches `SPI_Slave`'s received-byte stream and decodes a one-byte command (R/W bit plus address) per chip-select frame. For writes it issues register-bus writes; for reads it fetches register data and loads it into `SPI_Slave` for shifting out on MISO. All logic runs in the `i_Clk` domain. SPI pins and the SCLK domain stay inside `SPI_Slave`.

---
 rtl/spi_reg_pkg.sv | 27 ++
 rtl/spi_reg_ctrl_if.sv | 50 +++++
 rtl/spi_cs_edge.sv | 31 +++
 rtl/spi_reg_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register command sequencer.
// Holds the FSM state enum, command byte layout and status byte default.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_REQ,
        RD_LOAD,
        RDATA,
        WDATA,
        DISCARD
    } state_e;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;

    function automatic logic addr_in_range(
        input int unsigned addr,
        input int unsigned num_regs
    );
        return addr < num_regs;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte stream from SPI_Slave plus register bank bus, as one bundle.
// master = the sequencer, slave = SPI_Slave / register bank side.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
);

    logic              i_CS_n;
    logic              i_RX_DV;
    logic [7:0]        i_RX_Byte;
    logic              o_TX_DV;
    logic [7:0]        o_TX_Byte;
    logic [ADDR_W-1:0] o_Reg_Addr;
    logic              o_Reg_Wr_En;
    logic [7:0]        o_Reg_Wr_Data;
    logic              o_Reg_Rd_En;
    logic [7:0]        i_Reg_Rd_Data;
    logic              o_Busy;
    logic              o_Err;

    modport master (
        input  i_CS_n,
        input  i_RX_DV,
        input  i_RX_Byte,
        output o_TX_DV,
        output o_TX_Byte,
        output o_Reg_Addr,
        output o_Reg_Wr_En,
        output o_Reg_Wr_Data,
        output o_Reg_Rd_En,
        input  i_Reg_Rd_Data,
        output o_Busy,
        output o_Err
    );

    modport slave (
        output i_CS_n,
        output i_RX_DV,
        output i_RX_Byte,
        input  o_TX_DV,
        input  o_TX_Byte,
        input  o_Reg_Addr,
        input  o_Reg_Wr_En,
        input  o_Reg_Wr_Data,
        input  o_Reg_Rd_En,
        output i_Reg_Rd_Data,
        input  o_Busy,
        input  o_Err
    );

endinterface

// File: rtl/spi_cs_edge.sv
// Chip-select edge detector: one-cycle frame start / frame end pulses.
// CS held low through reset does not count as a new frame.
module spi_cs_edge (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_CS_n,
    output logic o_Frame_Start,
    output logic o_Frame_End
);

    logic cs_q;
    logic cs_d;

    // Next value is simply the current chip-select level.
    always_comb begin
        cs_d = i_CS_n;
    end

    // Previous CS level; resets low so only a fresh falling edge starts a frame.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cs_q <= 1'b0;
        end else begin
            cs_q <= cs_d;
        end
    end

    assign o_Frame_Start = cs_q & ~i_CS_n;
    assign o_Frame_End   = ~cs_q & i_CS_n;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: decodes R/W + address, drives register bus and MISO.
// Define SPI_REG_AUTOINC_EN for address auto-increment bursts.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         NUM_REGS    = 16,
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
    input logic            i_Clk,
    input logic            i_Rst,
    spi_reg_ctrl_if.master bus
);

    localparam int unsigned NREGS = NUM_REGS;

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              tx_dv_q,    tx_dv_d;
    logic [7:0]        tx_byte_q,  tx_byte_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic              wr_en_q,    wr_en_d;
    logic [7:0]        wr_data_q,  wr_data_d;
    logic              rd_en_q,    rd_en_d;
    logic              busy_q,     busy_d;
    logic              err_q,      err_d;

    logic                  frame_start;
    logic                  frame_end;
    logic [CMD_ADDR_MSB:0] cmd_addr;
    logic                  cmd_wr;

    assign cmd_addr = bus.i_RX_Byte[CMD_ADDR_MSB:0];
    assign cmd_wr   = bus.i_RX_Byte[CMD_RW_BIT];

`ifdef SPI_REG_AUTOINC_EN
    logic [ADDR_W:0] addr_inc;
    assign addr_inc = {1'b0, addr_q} + 1'b1;
`endif

    spi_cs_edge u_cs_edge (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_CS_n        (bus.i_CS_n),
        .o_Frame_Start (frame_start),
        .o_Frame_End   (frame_end)
    );

    // Next-state and registered-output logic for the command FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        reg_addr_d = reg_addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_en_d    = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = CMD;
                    addr_d    = '0;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = STATUS_BYTE;
                end
            end
            CMD: begin
                if (bus.i_RX_DV) begin
                    addr_d = ADDR_W'(cmd_addr);
                    if (!addr_in_range(32'(cmd_addr), NREGS)) begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end else if (cmd_wr) begin
                        state_d = WDATA;
                    end else begin
                        state_d    = RD_REQ;
                        rd_en_d    = 1'b1;
                        reg_addr_d = ADDR_W'(cmd_addr);
                    end
                end
            end
            RD_REQ: begin
                state_d = RD_LOAD;
            end
            RD_LOAD: begin
                tx_byte_d = bus.i_Reg_Rd_Data;
                tx_dv_d   = 1'b1;
                state_d   = RDATA;
            end
            RDATA: begin
                if (bus.i_RX_DV) begin
`ifdef SPI_REG_AUTOINC_EN
                    // Next read must be prefetched now, so overflow errors here.
                    if (addr_in_range(32'(addr_inc), NREGS)) begin
                        addr_d     = addr_inc[ADDR_W-1:0];
                        reg_addr_d = addr_inc[ADDR_W-1:0];
                        rd_en_d    = 1'b1;
                        state_d    = RD_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
`else
                    state_d = DISCARD;
`endif
                end
            end
            WDATA: begin
                if (bus.i_RX_DV) begin
`ifdef SPI_REG_AUTOINC_EN
                    // Writes flag overflow only when a byte lands past the end.
                    if (addr_in_range(32'(addr_q), NREGS)) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = bus.i_RX_Byte;
                        reg_addr_d = addr_q;
                        addr_d     = addr_inc[ADDR_W-1:0];
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
`else
                    wr_en_d    = 1'b1;
                    wr_data_d  = bus.i_RX_Byte;
                    reg_addr_d = addr_q;
                    state_d    = DISCARD;
`endif
                end
            end
            DISCARD: begin
                state_d = DISCARD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame end wins: byte still processed, but no new load or read.
        if (frame_end) begin
            state_d   = IDLE;
            tx_dv_d   = 1'b0;
            tx_byte_d = tx_byte_q;
            rd_en_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            reg_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'h00;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            reg_addr_q <= reg_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_TX_DV       = tx_dv_q;
    assign bus.o_TX_Byte     = tx_byte_q;
    assign bus.o_Reg_Addr    = reg_addr_q;
    assign bus.o_Reg_Wr_En   = wr_en_q;
    assign bus.o_Reg_Wr_Data = wr_data_q;
    assign bus.o_Reg_Rd_En   = rd_en_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_Err         = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl.
// Expectations follow SPI_REG_AUTOINC_EN where the burst rule matters.
module tb_spi_reg_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   wr_cnt;
    int   rd_cnt;
    int   err_cnt;
    int   txdv_cnt;
    logic [7:0] bank [16];

    spi_reg_ctrl_if #(.ADDR_W(7)) bus ();

    spi_reg_ctrl #(
        .NUM_REGS    (16),
        .ADDR_W      (7),
        .STATUS_BYTE (8'hA5)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: read data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (rst) bus.i_Reg_Rd_Data <= 8'h00;
        else if (bus.o_Reg_Rd_En) bus.i_Reg_Rd_Data <= bank[bus.o_Reg_Addr[3:0]];
    end

    // Strobe counters.
    always @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= 0;
            rd_cnt   <= 0;
            err_cnt  <= 0;
            txdv_cnt <= 0;
        end else begin
            if (bus.o_Reg_Wr_En) wr_cnt <= wr_cnt + 1;
            if (bus.o_Reg_Rd_En) rd_cnt <= rd_cnt + 1;
            if (bus.o_Err) err_cnt <= err_cnt + 1;
            if (bus.o_TX_DV) txdv_cnt <= txdv_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat (4) tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_RX_Byte = b;
        bus.i_RX_DV   = 1'b1;
        tick();
        bus.i_RX_DV   = 1'b0;
    endtask

    task automatic open_frame();
        bus.i_CS_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic close_frame();
        bus.i_CS_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_chk++; if (bus.o_TX_DV !== 1'b0) begin n_fail++; $display("FAIL rst_txdv: got %b want 0", bus.o_TX_DV); end
        n_chk++; if (bus.o_TX_Byte !== 8'h00) begin n_fail++; $display("FAIL rst_txbyte: got %h want 00", bus.o_TX_Byte); end
        n_chk++; if (bus.o_Reg_Addr !== 7'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.o_Reg_Addr); end
        n_chk++; if ({bus.o_Reg_Wr_En, bus.o_Reg_Rd_En, bus.o_Err} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b want 000", {bus.o_Reg_Wr_En, bus.o_Reg_Rd_En, bus.o_Err}); end
        n_chk++; if (bus.o_Reg_Wr_Data !== 8'h00) begin n_fail++; $display("FAIL rst_wdata: got %h want 00", bus.o_Reg_Wr_Data); end
        n_chk++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.o_Busy); end
        rst = 1'b0;
        tick();
        tick();
        bus.i_CS_n = 1'b0;
        tick();
        n_chk++; if (bus.o_TX_DV !== 1'b1) begin n_fail++; $display("FAIL start_txdv: got %b want 1", bus.o_TX_DV); end
        n_chk++; if (bus.o_TX_Byte !== 8'hA5) begin n_fail++; $display("FAIL start_status: got %h want a5", bus.o_TX_Byte); end
        n_chk++; if (bus.o_Busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", bus.o_Busy); end
        tick();
        n_chk++; if (bus.o_TX_DV !== 1'b0) begin n_fail++; $display("FAIL start_txdv_pulse: got %b want 0", bus.o_TX_DV); end
        close_frame();
        n_chk++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL end_busy: got %b want 0", bus.o_Busy); end
    endtask

    task automatic test_idle_rx();
        int w0;
        w0 = wr_cnt;
        send(8'h81);
        n_chk++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL idle_rx_busy: got %b want 0", bus.o_Busy); end
        tick();
        n_chk++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL idle_rx_writes: got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_single_write();
        int w0;
        w0 = wr_cnt;
        open_frame();
        send(8'h83);
        n_chk++; if (bus.o_Reg_Wr_En !== 1'b0) begin n_fail++; $display("FAIL wr_cmd_strobe: got %b want 0", bus.o_Reg_Wr_En); end
        gap();
        send(8'h5C);
        n_chk++; if (bus.o_Reg_Wr_En !== 1'b1) begin n_fail++; $display("FAIL wr_strobe: got %b want 1", bus.o_Reg_Wr_En); end
        n_chk++; if (bus.o_Reg_Addr !== 7'd3) begin n_fail++; $display("FAIL wr_addr: got %0d want 3", bus.o_Reg_Addr); end
        n_chk++; if (bus.o_Reg_Wr_Data !== 8'h5C) begin n_fail++; $display("FAIL wr_data: got %h want 5c", bus.o_Reg_Wr_Data); end
        tick();
        n_chk++; if (bus.o_Reg_Wr_En !== 1'b0) begin n_fail++; $display("FAIL wr_pulse: got %b want 0", bus.o_Reg_Wr_En); end
        close_frame();
        n_chk++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", wr_cnt - w0); end
    endtask

    task automatic test_single_read();
        open_frame();
        send(8'h05);
        n_chk++; if (bus.o_Reg_Rd_En !== 1'b1) begin n_fail++; $display("FAIL rd_strobe: got %b want 1", bus.o_Reg_Rd_En); end
        n_chk++; if (bus.o_Reg_Addr !== 7'd5) begin n_fail++; $display("FAIL rd_addr: got %0d want 5", bus.o_Reg_Addr); end
        tick();
        n_chk++; if ({bus.o_Reg_Rd_En, bus.o_TX_DV} !== 2'b00) begin n_fail++; $display("FAIL rd_load_cycle: got %b want 00", {bus.o_Reg_Rd_En, bus.o_TX_DV}); end
        tick();
        n_chk++; if (bus.o_TX_DV !== 1'b1) begin n_fail++; $display("FAIL rd_txdv: got %b want 1", bus.o_TX_DV); end
        n_chk++; if (bus.o_TX_Byte !== 8'h3E) begin n_fail++; $display("FAIL rd_txbyte: got %h want 3e", bus.o_TX_Byte); end
        tick();
        n_chk++; if (bus.o_TX_DV !== 1'b0) begin n_fail++; $display("FAIL rd_txdv_pulse: got %b want 0", bus.o_TX_DV); end
        gap();
        send(8'h00);
`ifdef SPI_REG_AUTOINC_EN
        n_chk++; if (bus.o_Reg_Rd_En !== 1'b1) begin n_fail++; $display("FAIL rd_burst_strobe: got %b want 1", bus.o_Reg_Rd_En); end
        n_chk++; if (bus.o_Reg_Addr !== 7'd6) begin n_fail++; $display("FAIL rd_burst_addr: got %0d want 6", bus.o_Reg_Addr); end
`else
        n_chk++; if (bus.o_Reg_Rd_En !== 1'b0) begin n_fail++; $display("FAIL rd_single_strobe: got %b want 0", bus.o_Reg_Rd_En); end
`endif
        close_frame();
    endtask

    task automatic test_range_err();
        int w0, r0, e0, t0;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; t0 = txdv_cnt;
        open_frame();
        send(8'h90);
        n_chk++; if (bus.o_Err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", bus.o_Err); end
        tick();
        n_chk++; if (bus.o_Err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", bus.o_Err); end
        gap();
        send(8'h11);
        gap();
        send(8'h02);
        gap();
        n_chk++; if (bus.o_TX_Byte !== 8'hA5) begin n_fail++; $display("FAIL err_txbyte_hold: got %h want a5", bus.o_TX_Byte); end
        n_chk++; if (bus.o_Busy !== 1'b1) begin n_fail++; $display("FAIL err_busy: got %b want 1", bus.o_Busy); end
        close_frame();
        n_chk++; if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin n_fail++; $display("FAIL err_no_strobes: got %0d want 0", (wr_cnt - w0) + (rd_cnt - r0)); end
        n_chk++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL err_count: got %0d want 1", err_cnt - e0); end
        n_chk++; if (txdv_cnt - t0 !== 1) begin n_fail++; $display("FAIL err_txdv_count: got %0d want 1", txdv_cnt - t0); end
    endtask

    task automatic test_burst();
        int w0, e0;
        w0 = wr_cnt; e0 = err_cnt;
        open_frame();
        send(8'h8E);
        gap();
        send(8'h11);
        n_chk++; if ({bus.o_Reg_Wr_En, bus.o_Reg_Addr, bus.o_Reg_Wr_Data} !== {1'b1, 7'd14, 8'h11}) begin n_fail++; $display("FAIL burst_w0: got en=%b a=%0d d=%h want en=1 a=14 d=11", bus.o_Reg_Wr_En, bus.o_Reg_Addr, bus.o_Reg_Wr_Data); end
        gap();
        send(8'h22);
`ifdef SPI_REG_AUTOINC_EN
        n_chk++; if ({bus.o_Reg_Wr_En, bus.o_Reg_Addr, bus.o_Reg_Wr_Data} !== {1'b1, 7'd15, 8'h22}) begin n_fail++; $display("FAIL burst_w1: got en=%b a=%0d d=%h want en=1 a=15 d=22", bus.o_Reg_Wr_En, bus.o_Reg_Addr, bus.o_Reg_Wr_Data); end
`else
        n_chk++; if (bus.o_Reg_Wr_En !== 1'b0) begin n_fail++; $display("FAIL burst_w1: got %b want 0", bus.o_Reg_Wr_En); end
`endif
        gap();
        send(8'h33);
`ifdef SPI_REG_AUTOINC_EN
        n_chk++; if ({bus.o_Err, bus.o_Reg_Wr_En} !== 2'b10) begin n_fail++; $display("FAIL burst_w2: got err,en=%b want 10", {bus.o_Err, bus.o_Reg_Wr_En}); end
`else
        n_chk++; if ({bus.o_Err, bus.o_Reg_Wr_En} !== 2'b00) begin n_fail++; $display("FAIL burst_w2: got err,en=%b want 00", {bus.o_Err, bus.o_Reg_Wr_En}); end
`endif
        close_frame();
`ifdef SPI_REG_AUTOINC_EN
        n_chk++; if ({wr_cnt - w0, err_cnt - e0} !== {32'd2, 32'd1}) begin n_fail++; $display("FAIL burst_counts: got wr=%0d err=%0d want wr=2 err=1", wr_cnt - w0, err_cnt - e0); end
`else
        n_chk++; if ({wr_cnt - w0, err_cnt - e0} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL burst_counts: got wr=%0d err=%0d want wr=1 err=0", wr_cnt - w0, err_cnt - e0); end
`endif
    endtask

    task automatic test_abort();
        int t0, w0;
        t0 = txdv_cnt;
        open_frame();
        send(8'h05);
        bus.i_CS_n = 1'b1;
        tick();
        n_chk++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.o_Busy); end
        n_chk++; if (bus.o_TX_DV !== 1'b0) begin n_fail++; $display("FAIL abort_txdv: got %b want 0", bus.o_TX_DV); end
        tick();
        n_chk++; if (bus.o_TX_DV !== 1'b0) begin n_fail++; $display("FAIL abort_txdv_late: got %b want 0", bus.o_TX_DV); end
        tick();
        n_chk++; if (txdv_cnt - t0 !== 1) begin n_fail++; $display("FAIL abort_txdv_count: got %0d want 1", txdv_cnt - t0); end
        w0 = wr_cnt;
        open_frame();
        send(8'h82);
        gap();
        bus.i_RX_Byte = 8'h77;
        bus.i_RX_DV   = 1'b1;
        bus.i_CS_n    = 1'b1;
        tick();
        bus.i_RX_DV   = 1'b0;
        n_chk++; if ({bus.o_Reg_Wr_En, bus.o_Reg_Addr, bus.o_Reg_Wr_Data} !== {1'b1, 7'd2, 8'h77}) begin n_fail++; $display("FAIL coinc_write: got en=%b a=%0d d=%h want en=1 a=2 d=77", bus.o_Reg_Wr_En, bus.o_Reg_Addr, bus.o_Reg_Wr_Data); end
        n_chk++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL coinc_busy: got %b want 0", bus.o_Busy); end
        tick();
        tick();
        n_chk++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL coinc_count: got %0d want 1", wr_cnt - w0); end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        open_frame();
        send(8'h81);
        n_chk++; if (bus.o_Busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b want 1", bus.o_Busy); end
        rst = 1'b1;
        #1;
        n_chk++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy: got %b want 0", bus.o_Busy); end
        tick();
        rst = 1'b0;
        t0 = txdv_cnt;
        repeat (3) tick();
        n_chk++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_restart: got %b want 0", bus.o_Busy); end
        n_chk++; if (txdv_cnt - t0 !== 0) begin n_fail++; $display("FAIL mid_no_txdv: got %0d want 0", txdv_cnt - t0); end
        close_frame();
        bus.i_CS_n = 1'b0;
        tick();
        n_chk++; if ({bus.o_TX_DV, bus.o_TX_Byte} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL mid_fresh_start: got dv=%b b=%h want dv=1 b=a5", bus.o_TX_DV, bus.o_TX_Byte); end
        close_frame();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.i_CS_n    = 1'b1;
        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
        for (int i = 0; i < 16; i++) bank[i] = 8'(8'h39 + i);
        test_reset();
        test_idle_rx();
        test_single_write();
        test_single_read();
        test_range_err();
        test_burst();
        test_abort();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
